// File: rtl/csa_accum.sv
// csa_accum: multi-operand accumulator holding its running total in carry-save form.
// A single carry-propagate add per group runs in a dedicated cycle, off the accumulate path.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module csa_accum #(
  parameter int IN_W   = 16,
  parameter int ACC_W  = 24,
  parameter int SIGNED = 0,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count
);
  typedef enum logic [1:0] {ACC, RES, OUT} state_t;
  state_t           r_state;
  logic [ACC_W-1:0] r_s, r_c, r_out_data;
  logic [CNT_W-1:0] r_cnt, r_out_count;
  logic [ACC_W-1:0] w_ext, w_cs, w_sum, w_car;
  assign w_ext = (SIGNED != 0) ? ACC_W'($signed(in_data)) : ACC_W'(in_data);
  assign w_cs  = r_c << 1;
  for (genvar i = 0; i < ACC_W; i++) begin : g_csa
    full_adder u_fa (.a(r_s[i]), .b(w_cs[i]), .ci(w_ext[i]), .s(w_sum[i]), .co(w_car[i]));
  end
  assign in_ready  = rst_n & (r_state == ACC);
  assign out_valid = (r_state == OUT);
  assign out_data  = r_out_data;
  assign out_count = r_out_count;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ACC;
      r_s         <= '0;
      r_c         <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_count <= '0;
    end else begin
      case (r_state)
        ACC: if (in_valid) begin
          r_s   <= w_sum;
          r_c   <= w_car;
          r_cnt <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
          if (in_last) r_state <= RES;
        end
        RES: begin
          r_out_data  <= r_s + (r_c << 1);
          r_out_count <= r_cnt;
          r_state     <= OUT;
        end
        OUT: if (out_ready) begin
          r_s     <= '0;
          r_c     <= '0;
          r_cnt   <= '0;
          r_state <= ACC;
        end
        default: r_state <= ACC;
      endcase
    end
  end
endmodule

// File: tb/tb_csa_accum.sv
// tb_csa_accum: drives three csa_accum configurations with shared stimulus
// (unsigned 24b, signed 24b, unsigned 16b with 2-bit counter) and scoreboards the results.
module tb_csa_accum;
  logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic [15:0] in_data = 0;
  logic rdy0, rdy1, rdy2, v0, v1, v2;
  logic [23:0] d0, d1;
  logic [15:0] d2;
  logic [7:0] c0, c1;
  logic [1:0] c2;
  always #5 clk = ~clk;

  csa_accum #(.IN_W(16), .ACC_W(24), .SIGNED(0), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .in_last(in_last), .out_valid(v0), .out_ready(out_ready), .out_data(d0), .out_count(c0));
  csa_accum #(.IN_W(16), .ACC_W(24), .SIGNED(1), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .in_last(in_last), .out_valid(v1), .out_ready(out_ready), .out_data(d1), .out_count(c1));
  csa_accum #(.IN_W(16), .ACC_W(16), .SIGNED(0), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
    .in_last(in_last), .out_valid(v2), .out_ready(out_ready), .out_data(d2), .out_count(c2));

  typedef struct packed {
    logic [23:0] e0;
    logic [23:0] e1;
    logic [15:0] e2;
    logic [7:0]  c0;
    logic [1:0]  c2;
  } exp_t;
  typedef struct {
    int          n;
    logic [15:0] b[6];
    exp_t        e;
  } vec_t;

  exp_t q[$];
  vec_t vecs[7];
  int checks = 0, errs = 0;
  logic [23:0] m0 = 0, m1 = 0;
  logic [15:0] m2 = 0;
  logic [7:0]  mc0 = 0;
  logic [1:0]  mc2 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    m0 = 0; m1 = 0; m2 = 0; mc0 = 0; mc2 = 0;
  endtask

  task automatic beat(input logic [15:0] d, input logic last, input logic push);
    in_valid = 1; in_data = d; in_last = last;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; in_last = 0; in_data = 16'hDEAD;
    m0 = m0 + {8'h00, d};
    m1 = m1 + {{8{d[15]}}, d};
    m2 = m2 + d;
    if (mc0 != 8'hFF) mc0 = mc0 + 1;
    if (mc2 != 2'd3) mc2 = mc2 + 1;
    if (last) begin
      if (push) q.push_back('{m0, m1, m2, mc0, mc2});
      model_clear();
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1 chk("in_ready_in_reset", {29'd0, rdy0, rdy1, rdy2}, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_clear();
  endtask

  task automatic collect(input int stall);
    exp_t e;
    int k = 0;
    chk("res_cycle_valid", {31'd0, v0}, 0);
    while (!v0 && k < 4) begin @(negedge clk); k++; end
    chk("result_latency", k, 1);
    if (q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
      return;
    end
    e = q.pop_front();
    chk("valid_all", {29'd0, v0, v1, v2}, 7);
    chk("data_u0", {8'd0, d0}, {8'd0, e.e0});
    chk("data_u1", {8'd0, d1}, {8'd0, e.e1});
    chk("data_u2", {16'd0, d2}, {16'd0, e.e2});
    chk("count_u0", {24'd0, c0}, {24'd0, e.c0});
    chk("count_u1", {24'd0, c1}, {24'd0, e.c0});
    chk("count_u2", {30'd0, c2}, {30'd0, e.c2});
    for (int s = 0; s < stall; s++) begin
      in_valid = 1; in_data = 16'h1111; in_last = 1;
      chk("stall_in_ready", {29'd0, rdy0, rdy1, rdy2}, 0);
      @(negedge clk);
      chk("stall_data", {8'd0, d0}, {8'd0, e.e0});
      chk("stall_count", {24'd0, c0}, {24'd0, e.c0});
      chk("stall_valid", {31'd0, v0}, 1);
    end
    in_valid = 0; in_last = 0;
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("post_hs_valid", {31'd0, v0}, 0);
    chk("post_hs_ready", {29'd0, rdy0, rdy1, rdy2}, 7);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{3, '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 16'h0},
                '{24'h02FFFD, 24'hFFFFFD, 16'hFFFD, 8'd3, 2'd3}};
    vecs[1] = '{2, '{16'hFFFF, 16'h0002, 16'h0, 16'h0, 16'h0, 16'h0},
                '{24'h010001, 24'h000001, 16'h0001, 8'd2, 2'd2}};
    vecs[2] = '{1, '{16'h8000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                '{24'h008000, 24'hFF8000, 16'h8000, 8'd1, 2'd1}};
    vecs[3] = '{2, '{16'h8000, 16'h8000, 16'h0, 16'h0, 16'h0, 16'h0},
                '{24'h010000, 24'hFF0000, 16'h0000, 8'd2, 2'd2}};
    vecs[4] = '{5, '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0},
                '{24'h000005, 24'h000005, 16'h0005, 8'd5, 2'd3}};
    vecs[5] = '{1, '{16'h0007, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                '{24'h000007, 24'h000007, 16'h0007, 8'd1, 2'd1}};
    vecs[6] = '{4, '{16'h1234, 16'h0FFF, 16'h7000, 16'h9ABC, 16'h0, 16'h0},
                '{24'h012CEF, 24'h002CEF, 16'h2CEF, 8'd4, 2'd3}};
    @(negedge clk);
    @(negedge clk);
    chk("reset_valid", {29'd0, v0, v1, v2}, 0);
    chk("reset_data", {8'd0, d0}, 0);
    chk("reset_count", {24'd0, c0}, 0);
    chk("reset_in_ready", {29'd0, rdy0, rdy1, rdy2}, 0);
    rst_n = 1;
    #1 chk("ready_after_reset", {29'd0, rdy0, rdy1, rdy2}, 7);
    @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      q.push_back(vecs[i].e);
      for (int j = 0; j < vecs[i].n; j++) beat(vecs[i].b[j], j == vecs[i].n - 1, 0);
      collect(i == 4 ? 5 : 0);
    end
    // partial group discarded by reset
    beat(16'h0010, 0, 0);
    beat(16'h0020, 0, 0);
    do_reset();
    q.push_back('{24'h000005, 24'h000005, 16'h0005, 8'd1, 2'd1});
    beat(16'h0005, 1, 0);
    collect(0);
    // reset while a result is pending
    beat(16'h0009, 1, 0);
    @(negedge clk);
    chk("out_pending_valid", {31'd0, v0}, 1);
    rst_n = 0;
    @(posedge clk);
    #1;
    chk("reset_in_out_valid", {29'd0, v0, v1, v2}, 0);
    chk("reset_in_out_data", {8'd0, d0}, 0);
    chk("reset_in_out_count", {24'd0, c0}, 0);
    @(negedge clk);
    rst_n = 1;
    model_clear();
    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(1, 300);
      for (int j = 0; j < n; j++) beat(16'($urandom), j == n - 1, 1);
      collect($urandom_range(0, 3));
    end
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
